// File: rtl/decode_stage.sv
// Instruction-decode stage: IF/ID register, field decode, register-file addressing,
// WB-to-ID bypass, load-use stall detection and the ID/EX pipeline register.
module decode_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [DATA_WIDTH-1:0]     IF_Instruction,
    input  logic                      IF_Valid,
    output logic                      ID_Stall,
    input  logic                      Flush,
    output logic [REG_ADDR_WIDTH-1:0] Read_Register_1,
    output logic [REG_ADDR_WIDTH-1:0] Read_Register_2,
    input  logic [DATA_WIDTH-1:0]     Read_Data_1,
    input  logic [DATA_WIDTH-1:0]     Read_Data_2,
    input  logic [REG_ADDR_WIDTH-1:0] WB_Write_Register,
    input  logic [DATA_WIDTH-1:0]     WB_Write_Data,
    input  logic                      WB_Reg_Write,
    output logic                      EX_Valid,
    output logic [DATA_WIDTH-1:0]     EX_Read_Data_1,
    output logic [DATA_WIDTH-1:0]     EX_Read_Data_2,
    output logic [DATA_WIDTH-1:0]     EX_Immediate,
    output logic [REG_ADDR_WIDTH-1:0] EX_Write_Register,
    output logic [5:0]                EX_Funct,
    output logic [1:0]                EX_ALU_Op,
    output logic                      EX_Sig_Reg_Write,
    output logic                      EX_Sig_Mem_Read,
    output logic                      EX_Sig_Mem_Write,
    output logic                      EX_Sig_ALU_Src,
    output logic                      EX_Sig_Branch,
    output logic                      EX_Illegal
);

    localparam int unsigned IMM_WIDTH = 16;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     rd1;
        logic [DATA_WIDTH-1:0]     rd2;
        logic [DATA_WIDTH-1:0]     imm;
        logic [REG_ADDR_WIDTH-1:0] wr;
        logic [5:0]                funct;
        logic [1:0]                alu_op;
        logic                      reg_write;
        logic                      mem_read;
        logic                      mem_write;
        logic                      alu_src;
        logic                      branch;
        logic                      illegal;
    } idex_t;

    logic [DATA_WIDTH-1:0]     ifid_instr;
    logic                      ifid_valid;
    idex_t                     idex_q;
    idex_t                     idex_d;

    logic [5:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      uses_rt;
    logic                      hazard;

    assign opcode = ifid_instr[31:26];
    assign rs     = ifid_instr[25:21];
    assign rt     = ifid_instr[20:16];
    assign rd     = ifid_instr[15:11];

    assign Read_Register_1 = rs;
    assign Read_Register_2 = rt;

    // Load-use hazard: the load in EX writes a register this instruction reads.
    assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    assign hazard  = idex_q.valid && idex_q.mem_read && (idex_q.wr != '0) && ifid_valid &&
                     ((idex_q.wr == rs) || (uses_rt && (idex_q.wr == rt)));
    assign ID_Stall = hazard && !Flush;

    // Decode of the IF/ID instruction, with operand bypass from writeback.
    always_comb begin
        idex_d = '0;
        if (ifid_valid && !ID_Stall && !Flush) begin
            idex_d.valid = 1'b1;
            idex_d.imm   = {{(DATA_WIDTH-IMM_WIDTH){ifid_instr[15]}}, ifid_instr[15:0]};
            idex_d.funct = ifid_instr[5:0];
            idex_d.wr    = (opcode == OP_RTYPE) ? rd : rt;

            if (rs == '0)
                idex_d.rd1 = '0;
            else if (WB_Reg_Write && (WB_Write_Register == rs))
                idex_d.rd1 = WB_Write_Data;
            else
                idex_d.rd1 = Read_Data_1;

            if (rt == '0)
                idex_d.rd2 = '0;
            else if (WB_Reg_Write && (WB_Write_Register == rt))
                idex_d.rd2 = WB_Write_Data;
            else
                idex_d.rd2 = Read_Data_2;

            case (opcode)
                OP_RTYPE: begin
                    idex_d.reg_write = 1'b1;
                    idex_d.alu_op    = ALU_FUNCT;
                end
                OP_ADDI: begin
                    idex_d.reg_write = 1'b1;
                    idex_d.alu_src   = 1'b1;
                    idex_d.alu_op    = ALU_ADD;
                end
                OP_LW: begin
                    idex_d.reg_write = 1'b1;
                    idex_d.mem_read  = 1'b1;
                    idex_d.alu_src   = 1'b1;
                    idex_d.alu_op    = ALU_ADD;
                end
                OP_SW: begin
                    idex_d.mem_write = 1'b1;
                    idex_d.alu_src   = 1'b1;
                    idex_d.alu_op    = ALU_ADD;
                end
                OP_BEQ: begin
                    idex_d.branch = 1'b1;
                    idex_d.alu_op = ALU_SUB;
                end
                default: idex_d.illegal = 1'b1;
            endcase

            // Writes to R0 are architecturally discarded.
            if (idex_d.wr == '0)
                idex_d.reg_write = 1'b0;
        end
    end

    // IF/ID register: holds on stall, emptied by flush.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
        end else if (Flush) begin
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
        end else if (!ID_Stall) begin
            ifid_instr <= IF_Instruction;
            ifid_valid <= IF_Valid;
        end
    end

    // ID/EX register: bubbles are produced by the decode path.
    always_ff @(posedge Clk) begin
        if (Reset)
            idex_q <= '0;
        else
            idex_q <= idex_d;
    end

    assign EX_Valid          = idex_q.valid;
    assign EX_Read_Data_1    = idex_q.rd1;
    assign EX_Read_Data_2    = idex_q.rd2;
    assign EX_Immediate      = idex_q.imm;
    assign EX_Write_Register = idex_q.wr;
    assign EX_Funct          = idex_q.funct;
    assign EX_ALU_Op         = idex_q.alu_op;
    assign EX_Sig_Reg_Write  = idex_q.reg_write;
    assign EX_Sig_Mem_Read   = idex_q.mem_read;
    assign EX_Sig_Mem_Write  = idex_q.mem_write;
    assign EX_Sig_ALU_Src    = idex_q.alu_src;
    assign EX_Sig_Branch     = idex_q.branch;
    assign EX_Illegal        = idex_q.illegal;

endmodule
